// File: rtl/arb_word_packer.sv
// arb_word_packer: packs per-channel arbiter bytes into 32-bit words behind a valid/ready output queue
// Ports: clk, rst_n (sync, active-low); in_valid/in_data/in_src byte input, no backpressure;
// out_valid/out_ready/out_data/out_src word output (byte 0 in [7:0]); overflow sticky drop flag;
// drop_cnt saturating drop count, present only when PACKER_DROP_CNT_EN is defined.
module arb_word_packer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic [1:0]  in_src,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_src,
  output logic        overflow
`ifdef PACKER_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [23:0] part [4];
  logic [1:0]  cnt [4];
  logic [33:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic complete, pop, full, push, drop;
  assign complete  = in_valid && cnt[in_src] == 2'd3;
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign full      = count == (AW+1)'(DEPTH);
  // a pop in the same cycle frees the slot the completed word needs
  assign push      = complete && (!full || pop);
  assign drop      = complete && full && !pop;
  assign out_data  = mem[rp][31:0];
  assign out_src   = mem[rp][33:32];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        part[i] <= '0;
        cnt[i]  <= '0;
      end
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        cnt[in_src] <= cnt[in_src] + 2'd1;
        if (!complete) part[in_src][{cnt[in_src], 3'b000} +: 8] <= in_data;
      end
      if (push) begin
        mem[wp] <= {in_src, in_data, part[in_src]};
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
      if (drop) overflow <= 1'b1;
    end
  end
`ifdef PACKER_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_arb_word_packer.sv
// tb_arb_word_packer: directed self-checking bench for arb_word_packer
module tb_arb_word_packer;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] in_src = '0;
  logic out_valid, overflow;
  logic [31:0] out_data;
  logic [1:0] out_src;
  int total = 0, fails = 0;
`ifdef PACKER_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  arb_word_packer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_src(in_src),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .overflow(overflow)
`ifdef PACKER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [7:0] b);
    in_valid = 1'b1;
    in_src = s;
    in_data = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] s, input logic [7:0] base);
    for (int j = 0; j < 4; j++) send(s, base + 8'(j));
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] base);
    return {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endfunction

  task automatic pop_check(input string tag, input logic [31:0] d, input logic [1:0] s);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_src"}, out_src, s);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_src", out_src, 2'd0);
`ifdef PACKER_DROP_CNT_EN
    chk("rst_drop", drop_cnt, 8'd0);
`endif

    out_ready = 1'b1;
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    chk("single_not_yet", out_valid, 1'b0);
    send(0, 8'h44);
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 32'h44332211);
    chk("single_src", out_src, 2'd0);
    cyc();
    chk("single_popped", out_valid, 1'b0);
    out_ready = 1'b0;

    for (int idx = 0; idx < 4; idx++) begin
      send(1, 8'h10 + 8'(idx));
      send(2, 8'h20 + 8'(idx));
      send(3, 8'h30 + 8'(idx));
      send(0, 8'h00 + 8'(idx));
    end
    pop_check("il_c1", 32'h13121110, 2'd1);
    pop_check("il_c2", 32'h23222120, 2'd2);
    pop_check("il_c3", 32'h33323130, 2'd3);
    pop_check("il_c0", 32'h03020100, 2'd0);
    chk("il_empty", out_valid, 1'b0);
    chk("il_ovf", overflow, 1'b0);

    for (int k = 0; k < 4; k++) send_word(2, 8'h40 + 8'(4 * k));
    chk("full_noovf", overflow, 1'b0);
    chk("full_head_stable", out_data, word_of(8'h40));
    send_word(2, 8'h50);
    chk("full_ovf", overflow, 1'b1);
`ifdef PACKER_DROP_CNT_EN
    chk("full_drop1", drop_cnt, 8'd1);
`endif
    for (int k = 0; k < 4; k++) pop_check("full_pop", word_of(8'h40 + 8'(4 * k)), 2'd2);
    chk("full_empty", out_valid, 1'b0);
    chk("full_ovf_sticky", overflow, 1'b1);
    do_reset();
    chk("rst2_ovf", overflow, 1'b0);

    for (int k = 0; k < 4; k++) send_word(1, 8'h60 + 8'(4 * k));
    send(1, 8'h70);
    send(1, 8'h71);
    send(1, 8'h72);
    out_ready = 1'b1;
    send(1, 8'h73);
    out_ready = 1'b0;
    chk("simul_noovf", overflow, 1'b0);
    for (int k = 1; k < 5; k++) pop_check("simul_pop", word_of(8'h60 + 8'(4 * k)), 2'd1);
    chk("simul_empty", out_valid, 1'b0);

    send(3, 8'hAA);
    send(3, 8'hBB);
    do_reset();
    send_word(3, 8'h01);
    chk("midrst_ovf", overflow, 1'b0);
`ifdef PACKER_DROP_CNT_EN
    chk("midrst_drop", drop_cnt, 8'd0);
`endif
    pop_check("midrst", 32'h04030201, 2'd3);
    chk("midrst_empty", out_valid, 1'b0);

`ifdef PACKER_DROP_CNT_EN
    for (int k = 0; k < 4; k++) send_word(0, 8'h80);
    for (int k = 0; k < 255; k++) send_word(0, 8'h90);
    chk("sat_255", drop_cnt, 8'd255);
    for (int k = 0; k < 45; k++) send_word(0, 8'h90);
    chk("sat_300", drop_cnt, 8'd255);
    chk("sat_ovf", overflow, 1'b1);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
